// File: rtl/la_ioxtal_pkg.sv
// la_ioxtal_pkg: state encoding and helpers for the crystal oscillator supervisor
package la_ioxtal_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_MEAS    = 3'd2,
        S_GOOD    = 3'd3,
        S_BACKOFF = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/la_dsync.sv
// la_dsync: two-flop synchronizer for a single asynchronous level
module la_dsync (
    input  logic clk,
    input  logic nreset,
    input  logic i_in,
    output logic o_out
);

    logic [1:0] r_sync;

    // shift the asynchronous level through two flops
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_sync <= '0;
        else         r_sync <= {r_sync[0], i_in};
    end

    assign o_out = r_sync[1];

endmodule

// File: rtl/la_ioxtal_ctrl.sv
// la_ioxtal_ctrl: xtal startup, activity qualification, retry and error supervision
module la_ioxtal_ctrl
    import la_ioxtal_pkg::*;
#(
    parameter int CNTW    = 12,
    parameter int WINDOW  = 256,
    parameter int STARTUP = 1024,
    parameter int LOCKN   = 4,
    parameter int RETRIES = 3,
    parameter int RW      = 2
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            en,
    input  logic            xtal_tgl,
    input  logic [CNTW-1:0] cnt_min,
    input  logic [CNTW-1:0] cnt_max,
    output logic            xtal_en,
    output logic            xtal_good,
    output logic            error,
    output logic [2:0]      state,
    output logic [CNTW-1:0] edge_cnt,
    output logic [RW-1:0]   retry
);

    localparam int TW = $clog2(imax(STARTUP, WINDOW));
    localparam int GW = $clog2(LOCKN + 1);
    localparam logic [CNTW-1:0] SAT = '1;

    state_t          r_state, w_next, w_fail_dest;
    logic [TW-1:0]   r_timer;
    logic [CNTW-1:0] r_cnt, r_edge_cnt, w_total;
    logic [GW-1:0]   r_good_n;
    logic [RW-1:0]   r_retry;
    logic            r_prev, r_xtal_en, r_xtal_good, r_error;
    logic            w_sync, w_edge, w_win_end, w_pass, w_fail;

    la_dsync u_dsync (
        .clk    (clk),
        .nreset (nreset),
        .i_in   (xtal_tgl),
        .o_out  (w_sync)
    );

    assign w_edge      = w_sync ^ r_prev;
    assign w_win_end   = (r_state == S_MEAS || r_state == S_GOOD) && r_timer == TW'(WINDOW - 1);
    assign w_total     = (r_cnt == SAT) ? SAT : r_cnt + CNTW'(w_edge);
    assign w_pass      = (w_total >= cnt_min) && (w_total <= cnt_max);
    assign w_fail_dest = (r_retry == RW'(RETRIES)) ? S_ERROR : S_BACKOFF;

    // next state; en low overrides everything and returns to IDLE
    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        case (r_state)
            S_IDLE:    w_next = S_START;
            S_START:   if (r_timer == TW'(STARTUP - 1)) w_next = S_MEAS;
            S_MEAS, S_GOOD: if (w_win_end) begin
                w_fail = !w_pass;
                w_next = !w_pass ? w_fail_dest :
                         (r_state == S_GOOD || r_good_n == GW'(LOCKN - 1)) ? S_GOOD : S_MEAS;
            end
            S_BACKOFF: if (r_timer == TW'(WINDOW - 1)) w_next = S_START;
            S_ERROR:   w_next = S_ERROR;
            default:   w_next = S_IDLE;
        endcase
        if (!en) begin
            w_next = S_IDLE;
            w_fail = 1'b0;
        end
    end

    // state register and edge-detect history
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
            r_prev  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_prev  <= w_sync;
        end
    end

    // shared timer restarts on every state entry and at each window boundary
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                            r_timer <= '0;
        else if (w_next != r_state || w_win_end) r_timer <= '0;
        else                                    r_timer <= r_timer + 1'b1;
    end

    // saturating edge counter; only counts while measuring
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt      <= '0;
            r_edge_cnt <= '0;
        end else if (w_win_end) begin
            r_cnt      <= '0;
            r_edge_cnt <= w_total;
        end else begin
            r_cnt      <= (r_state == S_MEAS || r_state == S_GOOD) ? w_total : '0;
        end
    end

    // consecutive good windows in the current attempt
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                                     r_good_n <= '0;
        else if (r_state == S_START)                     r_good_n <= '0;
        else if (r_state == S_MEAS && w_win_end && w_pass) r_good_n <= r_good_n + 1'b1;
    end

    // failed-attempt count; cleared by lock or by disable
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                                  r_retry <= '0;
        else if (!en)                                 r_retry <= '0;
        else if (r_state == S_MEAS && w_next == S_GOOD) r_retry <= '0;
        else if (w_fail && w_next == S_BACKOFF)       r_retry <= r_retry + 1'b1;
    end

    // registered outputs follow the state being entered
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_xtal_en   <= 1'b0;
            r_xtal_good <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_xtal_en   <= w_next inside {S_START, S_MEAS, S_GOOD};
            r_xtal_good <= w_next == S_GOOD;
            r_error     <= w_next == S_ERROR;
        end
    end

    assign xtal_en   = r_xtal_en;
    assign xtal_good = r_xtal_good;
    assign error     = r_error;
    assign state     = r_state;
    assign edge_cnt  = r_edge_cnt;
    assign retry     = r_retry;

endmodule

// File: tb/tb_la_ioxtal_ctrl.sv
// tb_la_ioxtal_ctrl: randomized and directed checks against an arithmetic timing model
module tb_la_ioxtal_ctrl;

    localparam int STARTUP = 1024;
    localparam int WINDOW  = 256;
    localparam int LOCKN   = 4;
    localparam int RETRIES = 3;
    localparam int CNTW    = 12;
    localparam int T_GOOD  = 1 + STARTUP + LOCKN * WINDOW;
    localparam int T_FAIL1 = 1 + STARTUP + WINDOW;
    localparam int T_ERR   = 1 + (RETRIES + 1) * (STARTUP + WINDOW) + RETRIES * WINDOW;

    logic        clk = 1'b0;
    logic        nreset, en, xtal_tgl;
    logic [11:0] cnt_min, cnt_max, edge_cnt;
    logic        xtal_en, xtal_good, error;
    logic [2:0]  state;
    logic [1:0]  retry;

    logic        en2, tgl2;
    logic [3:0]  s_edge;
    logic        s_en, s_good, s_error;
    logic [2:0]  s_state;
    logic [0:0]  s_retry;

    int errors = 0;
    int checks = 0;
    int k_rate = 64;
    int phase  = 0;

    always #5 clk = ~clk;

    la_ioxtal_ctrl dut (
        .clk(clk), .nreset(nreset), .en(en), .xtal_tgl(xtal_tgl),
        .cnt_min(cnt_min), .cnt_max(cnt_max), .xtal_en(xtal_en),
        .xtal_good(xtal_good), .error(error), .state(state),
        .edge_cnt(edge_cnt), .retry(retry)
    );

    la_ioxtal_ctrl #(.CNTW(4), .WINDOW(16), .STARTUP(8), .LOCKN(1), .RETRIES(1), .RW(1)) dut_small (
        .clk(clk), .nreset(nreset), .en(en2), .xtal_tgl(tgl2),
        .cnt_min(4'd10), .cnt_max(4'd15), .xtal_en(s_en),
        .xtal_good(s_good), .error(s_error), .state(s_state),
        .edge_cnt(s_edge), .retry(s_retry)
    );

    // periodic toggle pattern: exactly k_rate toggles in any 256 consecutive cycles
    initial begin
        xtal_tgl = 1'b0;
        tgl2     = 1'b0;
        forever begin
            @(negedge clk);
            if (((phase % 256) + 1) * k_rate / 256 != (phase % 256) * k_rate / 256) xtal_tgl = ~xtal_tgl;
            tgl2  = ~tgl2;
            phase = phase + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int k, input int w);
        return (k > (1 << w) - 1) ? (1 << w) - 1 : k;
    endfunction

    function automatic bit passes(input int k, input int mn, input int mx);
        return sat(k, CNTW) >= mn && sat(k, CNTW) <= mx;
    endfunction

    task automatic restart(input int k, input int mn, input int mx);
        k_rate  = k;
        cnt_min = 12'(mn);
        cnt_max = 12'(mx);
        en = 1'b0;
        tick(1);
        chk("idle_state", 32'(state), 0);
        en = 1'b1;
        tick(1);
        chk("start_xtal_en", 32'(xtal_en), 1);
        chk("start_state", 32'(state), 1);
    endtask

    task automatic run_attempt(input int k, input int mn, input int mx);
        restart(k, mn, mx);
        if (passes(k, mn, mx)) begin
            tick(T_GOOD - 2);
            chk("good_early", 32'(xtal_good), 0);
            tick(1);
            chk("good_rise", 32'(xtal_good), 1);
            chk("good_state", 32'(state), 3);
            chk("good_edge_cnt", 32'(edge_cnt), 32'(sat(k, CNTW)));
            chk("good_retry", 32'(retry), 0);
        end else begin
            tick(T_FAIL1 - 2);
            chk("fail_meas_state", 32'(state), 2);
            tick(1);
            chk("fail_state", 32'(state), 4);
            chk("fail_retry", 32'(retry), 1);
            chk("fail_xtal_en", 32'(xtal_en), 0);
            chk("fail_edge_cnt", 32'(edge_cnt), 32'(sat(k, CNTW)));
            tick(WINDOW - 1);
            chk("backoff_hold", 32'(xtal_en), 0);
            tick(1);
            chk("backoff_restart", 32'(state), 1);
            chk("backoff_xtal_en", 32'(xtal_en), 1);
        end
    endtask

    task automatic err_attempt(input int k, input int mn, input int mx);
        restart(k, mn, mx);
        tick(T_ERR - 2);
        chk("err_early", 32'(error), 0);
        chk("err_early_state", 32'(state), 2);
        tick(1);
        chk("err_flag", 32'(error), 1);
        chk("err_state", 32'(state), 5);
        chk("err_retry", 32'(retry), RETRIES);
        chk("err_xtal_en", 32'(xtal_en), 0);
        chk("err_edge_cnt", 32'(edge_cnt), 32'(sat(k, CNTW)));
        tick(200);
        chk("err_sticky", 32'(error), 1);
        en = 1'b0;
        tick(1);
        chk("err_clear_state", 32'(state), 0);
        chk("err_clear_flag", 32'(error), 0);
        chk("err_clear_retry", 32'(retry), 0);
        chk("err_edge_hold", 32'(edge_cnt), 32'(sat(k, CNTW)));
    endtask

    initial begin
        int k, mn, mx;
        nreset  = 1'b0;
        en      = 1'b0;
        en2     = 1'b0;
        cnt_min = 12'd56;
        cnt_max = 12'd72;
        tick(2);
        chk("rst_state", 32'(state), 0);
        chk("rst_xtal_en", 32'(xtal_en), 0);
        chk("rst_good", 32'(xtal_good), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_edge_cnt", 32'(edge_cnt), 0);
        chk("rst_retry", 32'(retry), 0);
        nreset = 1'b1;
        tick(1);
        run_attempt(64, 56, 72);
        k_rate = 0;
        tick(WINDOW - 1);
        chk("good_hold", 32'(xtal_good), 1);
        tick(1);
        chk("lost_good", 32'(xtal_good), 0);
        chk("lost_state", 32'(state), 4);
        chk("lost_retry", 32'(retry), 1);
        k_rate = 64;
        tick(WINDOW + STARTUP + LOCKN * WINDOW - 1);
        chk("relock_early", 32'(xtal_good), 0);
        chk("relock_retry_early", 32'(retry), 1);
        tick(1);
        chk("relock_good", 32'(xtal_good), 1);
        chk("relock_retry", 32'(retry), 0);
        chk("relock_edge_cnt", 32'(edge_cnt), 64);
        run_attempt(56, 56, 72);
        run_attempt(72, 56, 72);
        run_attempt(55, 56, 72);
        run_attempt(73, 56, 72);
        err_attempt(0, 56, 72);
        err_attempt(64, 80, 40);
        restart(64, 56, 72);
        tick(1100);
        chk("pre_rst_state", 32'(state), 2);
        nreset = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 0);
        chk("async_rst_xtal_en", 32'(xtal_en), 0);
        chk("async_rst_edge_cnt", 32'(edge_cnt), 0);
        tick(1);
        nreset = 1'b1;
        run_attempt(64, 56, 72);
        en = 1'b0;
        tick(1);
        chk("endrop_state", 32'(state), 0);
        chk("endrop_good", 32'(xtal_good), 0);
        chk("endrop_xtal_en", 32'(xtal_en), 0);
        chk("endrop_edge_hold", 32'(edge_cnt), 64);
        run_attempt(64, 56, 72);
        for (int i = 0; i < 4; i++) begin
            k  = $urandom_range(40, 90);
            mn = $urandom_range(40, 70);
            mx = $urandom_range(50, 90);
            run_attempt(k, mn, mx);
        end
        en2 = 1'b1;
        tick(1 + 8 + 16 - 1);
        chk("small_good_early", 32'(s_good), 0);
        tick(1);
        chk("small_good", 32'(s_good), 1);
        chk("small_sat", 32'(s_edge), 32'(sat(16, 4)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
